// File: rtl/mp_ifetch.sv
`default_nettype none
// ============================================================================
// mp_ifetch : PC owner and fetch queue sitting in front of mp_icache (1-cycle)
// Revision  : 1.0
// ============================================================================
module mp_ifetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        sys_clk,
  input  logic        ifetch_rst_n,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_vld,
  input  logic [31:0] icache_data,
  input  logic        fetch_redir,
  input  logic [31:0] fetch_redir_pc,
  output logic        dec_vld,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        dec_rdy
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_W:0]   c_depth    = (CNT_W + 1)'(QUEUE_DEPTH);
  localparam logic [31:0]      c_pc_init  = RESET_PC & ~32'h3;

  logic [31:0]      r_pc;
  logic             r_inflight;
  logic [31:0]      r_inflight_pc;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [31:0]      r_q_inst [QUEUE_DEPTH];
  logic [31:0]      r_q_pc   [QUEUE_DEPTH];

  logic             w_deq;
  logic             w_enq;
  logic             w_issue;
  logic [CNT_W:0]   w_credit;

  assign dec_vld  = ifetch_rst_n && (r_count != '0);
  assign dec_inst = r_q_inst[r_rd_ptr];
  assign dec_pc   = r_q_pc[r_rd_ptr];
  assign w_deq    = dec_vld && dec_rdy;

  // Entries already queued, minus the one leaving, plus the one arriving next edge.
  assign w_credit = {1'b0, r_count} - (CNT_W + 1)'(w_deq) + (CNT_W + 1)'(r_inflight);
  assign w_issue  = ifetch_rst_n && !fetch_redir && (w_credit < c_depth);
  assign w_enq    = ifetch_rst_n && r_inflight && !fetch_redir;

  assign icache_req  = w_issue;
  assign icache_addr = r_pc;

  always_ff @(posedge sys_clk) begin
    if (!ifetch_rst_n) begin
      r_pc          <= c_pc_init;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else if (fetch_redir) begin
      r_pc       <= fetch_redir_pc & ~32'h3;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= r_pc + 32'd4;
        r_inflight_pc <= r_pc;
      end
      if (w_enq)
        r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
      if (w_deq)
        r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
    end
  end

  // Payload storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge sys_clk) begin
    if (w_enq) begin
      r_q_inst[r_wr_ptr] <= icache_data;
      r_q_pc[r_wr_ptr]   <= r_inflight_pc;
    end
  end

`ifndef SYNTHESIS
  always @(posedge sys_clk) begin
    if (w_enq) begin
      assert (!((r_count == CNT_W'(QUEUE_DEPTH)) && !w_deq));
      assert (icache_vld);
    end
  end
`endif

endmodule
`default_nettype wire
